uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning clk cycles per UART bit (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port um_rd  input  1  read strobe, already qualified by the initiator for the UART address window.
REQ-005 SHALL have port um_wr  input  1  write strobe, qualified the same way.
REQ-006 SHALL have port addr  input  32  byte address; only addr[7:0] decoded.
REQ-007 SHALL have port wdata  input  32  write data; only wdata[7:0] used.
REQ-008 SHALL have port um_data  output  32  read data, combinational from addr and um_rd.
REQ-009 SHALL have port rxd  input  1  asynchronous serial input, idle high.
REQ-010 SHALL have port txd  output  1  serial output, idle high.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL decode registers: 0x18 TXD (write-only), 0x1C RXD (read-only), 0x20 CON; any other addr[7:0]: read returns 0, write ignored.
REQ-013 SHALL return um_data=0 when um_rd=0; TXD reads return 0.
REQ-014 SHALL define CON: [0] rx_irq_en (RW), [1] tx_irq_en (RW), [2] rx_valid (RO), [3] tx_busy (RO), [4] rx_overrun (RO), [5] frame_err (RO), [6] parity_err (RO); bits [31:7] read 0.
REQ-015 SHALL make a CON write update only bits [1:0].
REQ-016 SHALL, on a TXD write at edge N with tx_busy=0, latch wdata[7:0], set tx_busy, and drive txd low from edge N+1.
REQ-017 SHALL ignore TXD writes while tx_busy=1 (no queue, byte dropped).
REQ-018 SHALL send start bit, 8 data bits LSB first, optional parity bit, stop bit (high), each exactly CLK_DIV cycles; tx_busy clears at the end of the stop bit, and a write in that same cycle is accepted.
REQ-019 SHALL pass rxd through a 2-flop synchronizer before any use.
REQ-020 SHALL run RX FSM IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE, entering START on a synchronized high-to-low transition.
REQ-021 SHALL re-sample at CLK_DIV/2 (integer) after the edge; if high, it is a false start and the FSM returns to IDLE with no flag change.
REQ-022 SHALL sample each later bit every CLK_DIV cycles from the start-bit midpoint.
REQ-023 SHALL, if the stop bit samples low, discard the byte and set frame_err, leaving rx_valid and RXD unchanged.
REQ-024 SHALL, on a good stop bit, load RXD and set rx_valid; if rx_valid was already 1, overwrite RXD and set rx_overrun.
REQ-025 SHALL clear rx_valid on an RXD read; when an RXD read and a byte completion coincide, the new byte loads and rx_valid stays 1.
REQ-026 SHALL clear rx_overrun, frame_err and parity_err on a CON read, unless set in the same cycle, in which case the set wins.
REQ-027 SHALL drive irq = (rx_irq_en & rx_valid) | (tx_irq_en & ~tx_busy), registered.

Reset
REQ-028 SHALL, on reset, force txd=1, irq=0, CON=0, RXD=0, TX and RX FSMs to IDLE, counters and synchronizer flops (to 1) cleared; reset mid-frame aborts the frame at the next edge.

Configuration
REQ-029 SHALL, when UART_PARITY_EN is defined, insert an even-parity bit after the data on TX and check it on RX, setting parity_err on mismatch (the byte is still delivered).
REQ-030 SHALL, without UART_PARITY_EN, use 10-bit frames, omit the PARITY state, and read CON[6] as 0.

Verification (CLK_DIV=16, parity off unless stated)
REQ-031 SHALL check: write 0x55 to 0x18 at cycle 0 -> txd low for cycles 1-16, data 1,0,1,0,1,0,1,0 over cycles 17-144, high from cycle 145; CON[3]=1 from cycle 1 through 160.
REQ-032 SHALL check: second TXD write (0xAA) at cycle 50 -> ignored, line shows only 0x55.
REQ-033 SHALL check: rxd frame 0xA5 at 16 cycles/bit -> RXD read returns 0xA5, CON[2]=1 then 0 after the read; with rx_irq_en=1, irq=1 until the read.
REQ-034 SHALL check: two frames 0x11, 0x22 with no read -> RXD=0x22, CON[4]=1; CON read clears bit 4.
REQ-035 SHALL check: 5-cycle low glitch on rxd -> no flag changes; frame with stop bit 0 -> CON[5]=1, rx_valid unchanged.
REQ-036 SHALL check, with UART_PARITY_EN: TX 0x07 -> parity bit 1, frame 176 cycles; RX 0x07 with parity 0 -> RXD=0x07, CON[6]=1.

Source files
------------

// File: rtl/uart_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_periph
// Brief    : Memory-mapped UART (TXD 0x18, RXD 0x1C, CON 0x20), 8N1 frames;
//            define UART_PARITY_EN for an even-parity bit (8E1 frames).
// Revision : 1.0 - initial release
// ============================================================================
module uart_periph #(
    parameter int CLK_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        um_rd,
    input  logic        um_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] um_data,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam logic [15:0] c_DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_HALF_M1 = 16'(CLK_DIV / 2 - 1);
`ifdef UART_PARITY_EN
    localparam int c_FRAME_BITS = 11;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    localparam int c_FRAME_BITS = 10;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
    localparam logic [3:0] c_TX_LAST = 4'(c_FRAME_BITS - 1);

    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    assign w_wr_txd = um_wr & (addr[7:0] == 8'h18);
    assign w_wr_con = um_wr & (addr[7:0] == 8'h20);
    assign w_rd_rxd = um_rd & (addr[7:0] == 8'h1C);
    assign w_rd_con = um_rd & (addr[7:0] == 8'h20);

    logic w_unused;
    assign w_unused = &{1'b0, addr[31:8], wdata[31:8]};

    logic r_rx_irq_en, r_tx_irq_en, r_irq;

    // ------------------------------------------------------------------ TX
    logic                    r_tx_busy, r_txd;
    logic [7:0]              r_tx_data;
    logic [15:0]             r_tx_cnt;
    logic [3:0]              r_tx_bit;
    logic [3:0]              w_tx_next;
    logic [c_FRAME_BITS-1:0] w_tx_frame;
    logic                    w_tx_done, w_tx_accept;

`ifdef UART_PARITY_EN
    assign w_tx_frame = {1'b1, ^r_tx_data, r_tx_data, 1'b0};
`else
    assign w_tx_frame = {1'b1, r_tx_data, 1'b0};
`endif
    assign w_tx_next   = r_tx_bit + 4'd1;
    assign w_tx_done   = r_tx_busy && (r_tx_cnt == c_DIV_M1) && (r_tx_bit == c_TX_LAST);
    // The final stop-bit cycle can accept the next byte for gapless frames.
    assign w_tx_accept = w_wr_txd && (!r_tx_busy || w_tx_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_busy <= 1'b0;
            r_tx_data <= 8'd0;
            r_tx_cnt  <= 16'd0;
            r_tx_bit  <= 4'd0;
            r_txd     <= 1'b1;
        end else if (w_tx_accept) begin
            r_tx_busy <= 1'b1;
            r_tx_data <= wdata[7:0];
            r_tx_cnt  <= 16'd0;
            r_tx_bit  <= 4'd0;
            r_txd     <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == c_DIV_M1) begin
                r_tx_cnt <= 16'd0;
                if (r_tx_bit == c_TX_LAST) begin
                    r_tx_busy <= 1'b0;
                    r_txd     <= 1'b1;
                end else begin
                    r_tx_bit <= w_tx_next;
                    r_txd    <= w_tx_frame[w_tx_next];
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end
    assign txd = r_txd;

    // ------------------------------------------------------------------ RX
    logic        r_rx_sync1, r_rx_sync2, r_rx_prev;
    rx_state_t   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift, r_rxd;
    logic        r_rx_valid, r_rx_overrun, r_frame_err;
    logic        w_rx_tick, w_rx_good, w_rx_bad, w_parity_err;

    assign w_rx_tick = (r_rx_cnt == c_DIV_M1);
    assign w_rx_good = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync2;
    assign w_rx_bad  = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync2;

`ifdef UART_PARITY_EN
    logic r_rx_par_bad, r_parity_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_par_bad <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if ((r_rx_state == RX_PARITY) && w_rx_tick)
                r_rx_par_bad <= r_rx_sync2 ^ (^r_rx_shift);
            if (w_rx_good && r_rx_par_bad)
                r_parity_err <= 1'b1;
            else if (w_rd_con)
                r_parity_err <= 1'b0;
        end
    end
    assign w_parity_err = r_parity_err;
`else
    assign w_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_sync1   <= 1'b1;
            r_rx_sync2   <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= 16'd0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_rxd        <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_sync1 <= rxd;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_rx_cnt   <= r_rx_cnt + 16'd1;
            case (r_rx_state)
                RX_IDLE: if (r_rx_prev && !r_rx_sync2) begin
                    r_rx_state <= RX_START;
                    r_rx_cnt   <= 16'd0;
                end
                RX_START: if (r_rx_cnt == c_HALF_M1) begin
                    r_rx_cnt   <= 16'd0;
                    r_rx_bit   <= 3'd0;
                    r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (w_rx_tick) begin
                    r_rx_cnt   <= 16'd0;
                    r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
`ifdef UART_PARITY_EN
                    if (r_rx_bit == 3'd7) r_rx_state <= RX_PARITY;
`else
                    if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
`endif
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (w_rx_tick) begin
                    r_rx_cnt   <= 16'd0;
                    r_rx_state <= RX_STOP;
                end
`endif
                RX_STOP: if (w_rx_tick) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase

            // A completing byte wins over a coincident RXD read.
            if (w_rx_good) begin
                r_rxd      <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_good && r_rx_valid && !w_rd_rxd) r_rx_overrun <= 1'b1;
            else if (w_rd_con)                        r_rx_overrun <= 1'b0;
            if (w_rx_bad)      r_frame_err <= 1'b1;
            else if (w_rd_con) r_frame_err <= 1'b0;
        end
    end

    // ------------------------------------------------------- CON / IRQ / bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_rx_irq_en <= wdata[0];
                r_tx_irq_en <= wdata[1];
            end
            r_irq <= (r_rx_irq_en & r_rx_valid) | (r_tx_irq_en & ~r_tx_busy);
        end
    end
    assign irq = r_irq;

    always_comb begin
        um_data = 32'd0;
        if (um_rd) begin
            case (addr[7:0])
                8'h1C:   um_data = {24'd0, r_rxd};
                8'h20:   um_data = {25'd0, w_parity_err, r_frame_err, r_rx_overrun,
                                    r_tx_busy, r_rx_valid, r_tx_irq_en, r_rx_irq_en};
                default: um_data = 32'd0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_periph
// Brief    : Self-checking bench for uart_periph (CLK_DIV=16); honours
//            UART_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_periph;
    localparam int DIV = 16;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = (PAR ? 11 : 10) * DIV;

    logic        clk = 1'b0, reset = 1'b1, um_rd = 1'b0, um_wr = 1'b0, rxd = 1'b1;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] um_data;
    logic        txd, irq;

    int n_checks = 0, n_pass = 0;

    // Reference model of the programmer-visible receive/CON state
    logic [7:0] m_rxd;
    logic       m_valid, m_ovr, m_ferr, m_perr, m_rxen, m_txen;

    always #5 clk = ~clk;

    uart_periph #(.CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .um_rd(um_rd), .um_wr(um_wr), .addr(addr),
        .wdata(wdata), .um_data(um_data), .rxd(rxd), .txd(txd), .irq(irq)
    );

    // Expected line level k cycles after the TXD write (k=1 is the first start-bit cycle)
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int idx;
        if (k < 1 || k > FLEN) return 1'b1;
        idx = (k - 1) / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [31:0] con_model(input logic busy);
        return {25'd0, m_perr, m_ferr, m_ovr, busy, m_valid, m_txen, m_rxen};
    endfunction

    task automatic model_reset();
        m_rxd = 8'd0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0; m_rxen = 0; m_txen = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_rxd = b;
            m_valid = 1'b1;
            if (PAR && !par_ok) m_perr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); addr = {24'd0, a}; wdata = d; um_wr = 1'b1;
        @(negedge clk); um_wr = 1'b0; addr = 32'd0;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk); addr = {24'd0, a}; um_rd = 1'b1;
        #1 d = um_data;
        @(negedge clk); um_rd = 1'b0; addr = 32'd0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic par);
        logic [10:0] f;
        int n;
        f = PAR ? {stop, par, b, 1'b0} : {1'b0, stop, b, 1'b0};
        n = PAR ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rxd = f[i];
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk); rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        read_reg(8'h20, d);
        n_checks++; if (d !== 32'd0) $display("FAIL reset_con: got %h want 0", d); else n_pass++;
        read_reg(8'h1C, d);
        n_checks++; if (d !== 32'd0) $display("FAIL reset_rxd: got %h want 0", d); else n_pass++;
        read_reg(8'h18, d);
        n_checks++; if (d !== 32'd0) $display("FAIL txd_reg_read: got %h want 0", d); else n_pass++;
    endtask

    // Send byte b; optionally write b2 during cycle c (c<0: no second write)
    task automatic test_tx(input logic [7:0] b, input logic [7:0] b2, input int c);
        logic acc, et, eb;
        int last;
        acc  = (c >= FLEN);
        last = acc ? c + FLEN + 4 : FLEN + 4;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
        @(negedge clk); addr = 32'h18; wdata = {24'd0, b}; um_wr = 1'b1; um_rd = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1 || k == c + 1) begin um_wr = 1'b0; addr = 32'h20; end
            if (k == c) begin addr = 32'h18; wdata = {24'd0, b2}; um_wr = 1'b1; end
            #1;
            et = (acc && k > c) ? exp_tx(b2, k - c) : exp_tx(b, k);
            eb = (k <= FLEN) || (acc && k > c && k <= c + FLEN);
            n_checks++;
            if (txd !== et) $display("FAIL tx_line b=%h c=%0d k=%0d: got %b want %b", b, c, k, txd, et);
            else n_pass++;
            if (k != c) begin
                n_checks++;
                if (um_data[3] !== eb) $display("FAIL tx_busy b=%h k=%0d: got %b want %b", b, k, um_data[3], eb);
                else n_pass++;
            end
        end
        um_rd = 1'b0; addr = 32'd0;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        write_reg(8'h18, 32'h00);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (txd !== 1'b1) $display("FAIL midframe_txd: got %b want 1", txd); else n_pass++;
        read_reg(8'h20, d);
        n_checks++; if (d !== 32'd0) $display("FAIL midframe_con: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_rx_basic(input logic [7:0] b);
        logic [31:0] d;
        write_reg(8'h20, 32'h1); m_rxen = 1'b1; m_txen = 1'b0;
        send_rx(b, 1'b1, ^b); model_frame(b, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (irq !== (m_rxen & m_valid)) $display("FAIL rx_irq_set b=%h: got %b want %b", b, irq, m_rxen & m_valid);
        else n_pass++;
        read_reg(8'h20, d);
        n_checks++; if (d !== con_model(1'b0)) $display("FAIL rx_con b=%h: got %h want %h", b, d, con_model(1'b0)); else n_pass++;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
        read_reg(8'h1C, d);
        n_checks++; if (d !== {24'd0, m_rxd}) $display("FAIL rx_data: got %h want %h", d, m_rxd); else n_pass++;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (irq !== (m_rxen & m_valid)) $display("FAIL rx_irq_clr: got %b want %b", irq, m_rxen & m_valid);
        else n_pass++;
        read_reg(8'h20, d);
        n_checks++; if (d !== con_model(1'b0)) $display("FAIL rx_con_after b=%h: got %h want %h", b, d, con_model(1'b0)); else n_pass++;
        write_reg(8'h20, 32'h0); m_rxen = 1'b0;
    endtask

    task automatic test_overrun(input logic [7:0] b1, input logic [7:0] b2);
        logic [31:0] d;
        send_rx(b1, 1'b1, ^b1); model_frame(b1, 1'b1, 1'b1);
        send_rx(b2, 1'b1, ^b2); model_frame(b2, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            read_reg(8'h20, d);
            n_checks++;
            if (d !== con_model(1'b0)) $display("FAIL overrun_con%0d: got %h want %h", i, d, con_model(1'b0));
            else n_pass++;
            m_ovr = 0; m_ferr = 0; m_perr = 0;
        end
        read_reg(8'h1C, d);
        n_checks++; if (d !== {24'd0, m_rxd}) $display("FAIL overrun_data: got %h want %h", d, m_rxd); else n_pass++;
        m_valid = 1'b0;
    endtask

    task automatic test_glitch_frame_err(input logic [7:0] b1, input logic [7:0] b2);
        logic [31:0] d;
        @(negedge clk); rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        read_reg(8'h20, d);
        n_checks++; if (d !== con_model(1'b0)) $display("FAIL glitch_con: got %h want %h", d, con_model(1'b0)); else n_pass++;
        send_rx(b1, 1'b1, ^b1); model_frame(b1, 1'b1, 1'b1);
        send_rx(b2, 1'b0, ^b2); model_frame(b2, 1'b0, 1'b1);
        read_reg(8'h20, d);
        n_checks++; if (d !== con_model(1'b0)) $display("FAIL frame_err_con: got %h want %h", d, con_model(1'b0)); else n_pass++;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
        read_reg(8'h1C, d);
        n_checks++; if (d !== {24'd0, m_rxd}) $display("FAIL frame_err_data: got %h want %h", d, m_rxd); else n_pass++;
        m_valid = 1'b0;
    endtask

    task automatic test_parity();
        logic [31:0] d;
        send_rx(8'h07, 1'b1, 1'b0); model_frame(8'h07, 1'b1, 1'b0 == ^8'h07);
        read_reg(8'h1C, d);
        n_checks++; if (d !== {24'd0, m_rxd}) $display("FAIL parity_data: got %h want %h", d, m_rxd); else n_pass++;
        m_valid = 1'b0;
        read_reg(8'h20, d);
        n_checks++; if (d !== con_model(1'b0)) $display("FAIL parity_con: got %h want %h", d, con_model(1'b0)); else n_pass++;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
    endtask

    task automatic test_tx_irq(input logic [7:0] b);
        write_reg(8'h20, 32'h2); m_txen = 1'b1; m_rxen = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (irq !== 1'b1) $display("FAIL txirq_idle: got %b want 1", irq); else n_pass++;
        write_reg(8'h18, {24'd0, b});
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (irq !== 1'b0) $display("FAIL txirq_busy: got %b want 0", irq); else n_pass++;
        repeat (FLEN) @(negedge clk);
        #1;
        n_checks++; if (irq !== 1'b1) $display("FAIL txirq_done: got %b want 1", irq); else n_pass++;
        write_reg(8'h20, 32'h0); m_txen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx(8'h55, 8'hAA, 50);
        test_tx(8'($urandom), 8'($urandom), -1);
        test_tx(8'($urandom), 8'($urandom), FLEN);
        test_reset_midframe();
        test_rx_basic(8'hA5);
        for (int i = 0; i < 3; i++) test_rx_basic(8'($urandom));
        test_overrun(8'h11, 8'h22);
        test_overrun(8'($urandom), 8'($urandom));
        test_glitch_frame_err(8'($urandom), 8'($urandom));
        if (PAR) test_parity();
        test_tx_irq(8'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
